// File: rtl/generador_tablero_if.sv
// Board generator interface: start request and bomb count in, finished board
// and status out.
//   iniciar          : start request (level, acted on at its rising edge)
//   cantBombas       : requested bomb count, sampled on the start cycle
//   tablero          : 8x8 board, 7-bit cell {bomba, revelada, bandera, count[3:0]}
//   listo            : board complete and stable
//   ocupado          : generation in progress
//   bombasColocadas  : bombs placed so far
// master = consumer issuing starts (buscaminas / bench), slave = generator.
interface generador_tablero_if;
    logic                  iniciar;
    logic [7:0]            cantBombas;
    logic [7:0][7:0][6:0]  tablero;
    logic                  listo;
    logic                  ocupado;
    logic [7:0]            bombasColocadas;

    modport master (
        output iniciar, cantBombas,
        input  tablero, listo, ocupado, bombasColocadas
    );

    modport slave (
        input  iniciar, cantBombas,
        output tablero, listo, ocupado, bombasColocadas
    );
endinterface

// File: rtl/generador_tablero.sv
// Board generator for the buscaminas core.
// On a rising edge of iniciar it clears the 8x8 board, drops min(cantBombas,63)
// bombs at cells picked by a free-running 16-bit LFSR, then scans all 64 cells
// writing each one's adjacent-bomb count, and finally raises listo.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : generador_tablero_if.slave (iniciar, cantBombas in; tablero, listo,
//          ocupado, bombasColocadas out, all registered)
module generador_tablero #(
    parameter int          FILAS    = 8,
    parameter int          COLUMNAS = 8,
    parameter logic [15:0] SEMILLA  = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    generador_tablero_if.slave   bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_PLACE = 3'd2;
    localparam logic [2:0] S_COUNT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            r_estado;
    logic [15:0]           r_lfsr;
    logic                  r_iniciar_q;
    logic [5:0]            r_objetivo;
    logic [5:0]            r_k;
    logic [7:0][7:0][6:0]  r_tablero;
    logic                  r_listo;
    logic                  r_ocupado;
    logic [7:0]            r_bombas;

    logic                  w_start;
    logic                  w_fb;
    logic [2:0]            w_cand_fila;
    logic [2:0]            w_cand_col;
    logic [2:0]            w_k_fila;
    logic [2:0]            w_k_col;
    logic [5:0]            w_objetivo_nuevo;
    logic [3:0]            w_vecinos;

    // Fibonacci feedback, taps 16,14,13,11 (bits 15,13,12,10), shifting left
    assign w_fb             = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_start          = bus.iniciar & ~r_iniciar_q;
    assign w_cand_fila      = r_lfsr[5:3];
    assign w_cand_col       = r_lfsr[2:0];
    assign w_k_fila         = r_k[5:3];
    assign w_k_col          = r_k[2:0];
    assign w_objetivo_nuevo = (bus.cantBombas > 8'd63) ? 6'd63 : bus.cantBombas[5:0];

    // Bomb count among in-bounds neighbours of scan cell k (no wrap-around)
    always_comb begin : cuenta_vecinos
        int fila_v;
        int col_v;
        w_vecinos = '0;
        fila_v    = 0;
        col_v     = 0;
        for (int unsigned df = 0; df < 3; df++) begin
            for (int unsigned dc = 0; dc < 3; dc++) begin
                fila_v = int'(w_k_fila) + int'(df) - 1;
                col_v  = int'(w_k_col) + int'(dc) - 1;
                if (!(df == 1 && dc == 1) &&
                    fila_v >= 0 && fila_v < FILAS &&
                    col_v  >= 0 && col_v  < COLUMNAS) begin
                    if (r_tablero[fila_v[2:0]][col_v[2:0]][6]) begin
                        w_vecinos = w_vecinos + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_estado    <= S_IDLE;
            r_lfsr      <= SEMILLA;
            r_iniciar_q <= 1'b0;
            r_objetivo  <= '0;
            r_k         <= '0;
            r_tablero   <= '0;
            r_listo     <= 1'b0;
            r_ocupado   <= 1'b0;
            r_bombas    <= '0;
        end else begin
            r_lfsr      <= {r_lfsr[14:0], w_fb};
            r_iniciar_q <= bus.iniciar;
            case (r_estado)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_objetivo <= w_objetivo_nuevo;
                        r_listo    <= 1'b0;
                        r_ocupado  <= 1'b1;
                        r_estado   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_tablero <= '0;
                    r_bombas  <= '0;
                    r_k       <= '0;
                    r_estado  <= (r_objetivo == 6'd0) ? S_COUNT : S_PLACE;
                end
                S_PLACE: begin
                    // occupied candidates are simply skipped; the LFSR moves on
                    if (!r_tablero[w_cand_fila][w_cand_col][6]) begin
                        r_tablero[w_cand_fila][w_cand_col][6] <= 1'b1;
                        r_bombas <= r_bombas + 8'd1;
                        if ((r_bombas + 8'd1) == {2'b00, r_objetivo}) begin
                            r_estado <= S_COUNT;
                        end
                    end
                end
                S_COUNT: begin
                    r_tablero[w_k_fila][w_k_col][3:0] <= w_vecinos;
                    r_k <= r_k + 6'd1;
                    if (r_k == 6'd63) begin
                        r_estado  <= S_DONE;
                        r_listo   <= 1'b1;
                        r_ocupado <= 1'b0;
                    end
                end
                default: r_estado <= S_IDLE;
            endcase
        end
    end

    assign bus.tablero         = r_tablero;
    assign bus.listo           = r_listo;
    assign bus.ocupado         = r_ocupado;
    assign bus.bombasColocadas = r_bombas;

endmodule

// File: tb/tb_generador_tablero.sv
// Directed self-checking bench for generador_tablero: reset, normal board,
// held start, retrigger, zero bombs, clamp to 63, reset in mid-placement.
module tb_generador_tablero;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    generador_tablero_if bus ();

    generador_tablero #(
        .FILAS    (8),
        .COLUMNAS (8),
        .SEMILLA  (16'hACE1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] vecinos(input logic [7:0][7:0][6:0] t, input int f, input int c);
        int n;
        int rf;
        int rc;
        n = 0;
        for (int df = -1; df <= 1; df++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rf = f + df;
                rc = c + dc;
                if (!(df == 0 && dc == 0) && rf >= 0 && rf < 8 && rc >= 0 && rc < 8) begin
                    if (t[rf][rc][6]) n++;
                end
            end
        end
        return n[3:0];
    endfunction

    function automatic logic [63:0] mascara(input logic [7:0][7:0][6:0] t);
        logic [63:0] m;
        m = '0;
        for (int f = 0; f < 8; f++)
            for (int c = 0; c < 8; c++)
                m[f*8+c] = t[f][c][6];
        return m;
    endfunction

    // Full board check: bomb total, placed counter, per-cell neighbour counts, bits [5:4]
    task automatic verify_board(input string tag, input int exp_bombs);
        logic [7:0][7:0][6:0] t;
        int bombas;
        int flags;
        t = bus.tablero;
        bombas = 0;
        flags  = 0;
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 8; c++) begin
                if (t[f][c][6]) bombas++;
                if (t[f][c][5:4] != 2'b00) flags++;
                check($sformatf("%s_cnt_%0d_%0d", tag, f, c), 64'(t[f][c][3:0]), 64'(vecinos(t, f, c)));
            end
        end
        check({tag, "_bombas"}, 64'(bombas), 64'(exp_bombs));
        check({tag, "_colocadas"}, 64'(bus.bombasColocadas), 64'(exp_bombs));
        check({tag, "_bits54"}, 64'(flags), 64'd0);
    endtask

    // Drop iniciar for 'espera' cycles, raise it, return cycles until listo
    task automatic start_and_wait(input string tag, input logic [7:0] n, input int espera, output int ciclos);
        bus.iniciar = 1'b0;
        repeat (espera) begin @(posedge clk); #1; end
        bus.cantBombas = n;
        bus.iniciar    = 1'b1;
        @(posedge clk); #1;
        ciclos = 1;
        check({tag, "_listo_cae"}, 64'(bus.listo), 64'd0);
        check({tag, "_ocupado"}, 64'(bus.ocupado), 64'd1);
        while (!bus.listo && ciclos < 4000) begin
            @(posedge clk); #1;
            ciclos++;
        end
        check({tag, "_listo"}, 64'(bus.listo), 64'd1);
        check({tag, "_ocupado_fin"}, 64'(bus.ocupado), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ciclos;
        int cambios;
        int libre_f;
        int libre_c;
        int libres;
        int borde;
        logic [63:0] m1;
        logic [63:0] m2;
        logic [7:0][7:0][6:0] snap;
        n_checks = 0;
        n_pass   = 0;

        // Reset hold with iniciar high
        rst = 1'b0;
        bus.iniciar    = 1'b1;
        bus.cantBombas = 8'd10;
        repeat (2) begin @(posedge clk); #1; end
        check("rst_tablero", 64'(bus.tablero == '0), 64'd1);
        check("rst_listo", 64'(bus.listo), 64'd0);
        check("rst_ocupado", 64'(bus.ocupado), 64'd0);
        check("rst_colocadas", 64'(bus.bombasColocadas), 64'd0);
        bus.iniciar = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("idle_ocupado", 64'(bus.ocupado), 64'd0);
        check("idle_listo", 64'(bus.listo), 64'd0);

        // Normal generation, 10 bombs; cantBombas changed after the start is ignored
        bus.cantBombas = 8'd10;
        bus.iniciar    = 1'b1;
        @(posedge clk); #1;
        bus.cantBombas = 8'd50;
        ciclos = 1;
        check("n10_ocupado", 64'(bus.ocupado), 64'd1);
        while (!bus.listo && ciclos < 4000) begin
            @(posedge clk); #1;
            ciclos++;
        end
        check("n10_listo", 64'(bus.listo), 64'd1);
        check("n10_lat_min", 64'(ciclos >= 76), 64'd1);
        verify_board("n10", 10);
        m1 = mascara(bus.tablero);

        // iniciar still held: no regeneration for 200 cycles
        snap = bus.tablero;
        cambios = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (bus.tablero != snap || !bus.listo || bus.ocupado) cambios++;
        end
        check("held_estable", 64'(cambios), 64'd0);

        // Retrigger at a different offset: new layout
        start_and_wait("retrig", 8'd10, 3, ciclos);
        verify_board("retrig", 10);
        m2 = mascara(bus.tablero);
        check("retrig_distinto", 64'(m1 != m2), 64'd1);

        // Zero bombs: fixed latency, empty board
        start_and_wait("cero", 8'd0, 2, ciclos);
        check("cero_latencia", 64'(ciclos), 64'd66);
        check("cero_vacio", 64'(bus.tablero == '0), 64'd1);
        verify_board("cero", 0);

        // Clamp: 200 requested -> 63 placed, one free cell
        start_and_wait("clamp", 8'd200, 5, ciclos);
        verify_board("clamp", 63);
        libres = 0;
        libre_f = 0;
        libre_c = 0;
        for (int f = 0; f < 8; f++)
            for (int c = 0; c < 8; c++)
                if (!bus.tablero[f][c][6]) begin
                    libres++;
                    libre_f = f;
                    libre_c = c;
                end
        check("clamp_libres", 64'(libres), 64'd1);
        borde = ((libre_f == 0 || libre_f == 7) ? 1 : 0) + ((libre_c == 0 || libre_c == 7) ? 1 : 0);
        check("clamp_libre_cnt", 64'(bus.tablero[libre_f][libre_c][3:0]),
              (borde == 2) ? 64'd3 : (borde == 1) ? 64'd5 : 64'd8);

        // Reset during placement
        bus.iniciar = 1'b0;
        @(posedge clk); #1;
        bus.cantBombas = 8'd40;
        bus.iniciar    = 1'b1;
        ciclos = 0;
        while (bus.bombasColocadas != 8'd5 && ciclos < 500) begin
            @(posedge clk); #1;
            ciclos++;
        end
        check("mid_llega5", 64'(bus.bombasColocadas), 64'd5);
        rst = 1'b0;
        #1;
        check("mid_tablero", 64'(bus.tablero == '0), 64'd1);
        check("mid_colocadas", 64'(bus.bombasColocadas), 64'd0);
        check("mid_ocupado", 64'(bus.ocupado), 64'd0);
        check("mid_listo", 64'(bus.listo), 64'd0);
        bus.iniciar = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        start_and_wait("post_rst", 8'd40, 2, ciclos);
        verify_board("post_rst", 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/generador_tablero.md
Name: generador_tablero

Overview:
- Upstream board generator for the buscaminas game core.
- On a start request it clears an 8x8 board and places a requested number of bombs at pseudo-random cells using a free-running LFSR.
- It then computes the adjacent-bomb count for every cell and presents the finished board, plus a done flag, for buscaminas to load.

Parameters:
- FILAS, 8, board rows (fixed 8; 3-bit indices)
- COLUMNAS, 8, board columns (fixed 8; 3-bit indices)
- SEMILLA, 16'hACE1, LFSR reset value, must be nonzero

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- iniciar  input  1  start request, level signal, acted on at its rising edge
- cantBombas  input  8  requested bomb count, sampled at start
- tablero  output  7 per cell, [7:0][7:0] array  cell word: [6]=bomba, [5]=revelada, [4]=bandera, [3:0]=adjacent bomb count 0..8
- listo  output  1  board complete and stable
- ocupado  output  1  generation in progress
- bombasColocadas  output  8  bombs placed so far

Behaviour:
- Reset (rst=0, asynchronous):
  - every tablero cell = 7'b0; listo=0; ocupado=0; bombasColocadas=0
  - LFSR=SEMILLA; state=IDLE; iniciar edge register=0
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every cycle in every state except reset, so the board depends on when iniciar arrives.
  - Cell index = LFSR[5:0]; row = [5:3], column = [2:0].
- Start:
  - Start = iniciar rising edge (iniciar registered, start = iniciar & ~iniciar_q), accepted only in IDLE or DONE.
  - Edges in CLEAR, PLACE or COUNT are ignored.
  - Holding iniciar high never retriggers.
- Bomb target: objetivo = min(cantBombas, 63), latched on the start cycle; later changes to cantBombas have no effect.
- FSM:
  - IDLE:
    - listo=0, ocupado=0; start -> CLEAR.
  - CLEAR, 1 cycle:
    - All cells = 0, bombasColocadas=0, ocupado=1, listo=0.
    - Next state: PLACE, or COUNT if objetivo=0.
  - PLACE, one candidate per cycle:
    - If the cell at LFSR[5:0] has bomba=0, set bomba=1 and increment bombasColocadas.
    - Otherwise reject and retry next cycle.
    - When bombasColocadas reaches objetivo (the increment cycle that makes them equal), go to COUNT.
    - Minimum occupancy is objetivo cycles.
    - Termination is guaranteed: the low 6 bits of the maximal LFSR visit all 64 values within its period.
  - COUNT, exactly 64 cycles:
    - Scan counter k=0..63, row-major: row=k[5:3], column=k[2:0].
    - Each cycle writes cell k's [3:0] = number of bomb bits among its in-bounds 8 neighbours.
    - Corners have 3 neighbours, edges 5, interior 8; no wrap-around.
    - Bomb cells also receive their neighbour count.
    - Bits [6:4] are not modified.
    - After k=63 -> DONE.
  - DONE:
    - listo=1, ocupado=0; tablero held stable.
    - Start -> CLEAR (listo drops the next cycle).
- Outputs are registered. Bits [5] and [4] are always 0 from this block; buscaminas owns them after loading.
- Reset mid-operation: immediate return to reset values, no partial board retained.
- Latency from the start edge to listo=1 is 1 + P + 64 cycles, where P ≥ objetivo is the number of PLACE cycles (P=0 when objetivo=0).

Test Plan:
- Reset hold: rst=0 for 2 cycles with iniciar=1 -> all 64 cells 0, listo=0, ocupado=0, bombasColocadas=0; no start fires while in reset.
- Normal generation: cantBombas=10, iniciar 0->1 -> within ≤1+P+64 cycles listo=1, exactly 10 cells with bit6=1, bombasColocadas=10; every cell's [3:0] matches a bench-computed neighbour count; bits [5:4]=0 everywhere.
- Zero bombs: cantBombas=0, start -> listo=1 exactly 66 cycles after the edge cycle (CLEAR + 64 COUNT + DONE entry); all cells 0.
- Clamp and boundary counts: cantBombas=200 -> bombasColocadas=63, exactly one cell with bit6=0. Its count must be 3, 5 or 8 by position; corner bomb cells hold count 3 (or 2 if the free cell is adjacent).
- Held start and retrigger:
  - iniciar held 1 after listo -> no regeneration, board unchanged for 200 cycles.
  - Drop iniciar and raise it again -> listo goes 0 the next cycle and a new board is generated; its bomb layout differs from the first when the start edges are at different cycle offsets.
- Reset mid-PLACE: cantBombas=40, assert rst=0 once bombasColocadas=5 -> same cycle: cells all 0, bombasColocadas=0, ocupado=0. After release, a fresh start generates a complete 40-bomb board.
